// File: rtl/ysyx_idu_pkg.sv
// ysyx_idu_pkg: shared constants for the instruction decode unit.
//   - RV32I major opcodes
//   - immediate format encodings (fmt_e)
//   - decode FSM state encodings (state_e)
//   - fixed-width decoded field bundle (fields_t)
//   - fmt_of(): maps a major opcode to its immediate format
package ysyx_idu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

  typedef enum logic {
    IDLE       = 1'b0,
    WAIT_READY = 1'b1
  } state_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       wen;
    logic       illegal;
    logic       ebreak;
  } fields_t;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM: f = FMT_I;
      OP_STORE:                              f = FMT_S;
      OP_BRANCH:                             f = FMT_B;
      OP_LUI, OP_AUIPC:                      f = FMT_U;
      OP_JAL:                                f = FMT_J;
      OP_OP:                                 f = FMT_R;
      default:                               f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ysyx_idu_immgen.sv
// ysyx_idu_immgen: combinational RV32I immediate generator.
//   inst : instruction word (DATA_W)
//   imm  : sign-extended immediate, 0 for formats without one (DATA_W)
//   fmt  : immediate format selected from the opcode
module ysyx_idu_immgen
  import ysyx_idu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] imm,
  output fmt_e              fmt
);

  logic [31:0] imm32;

  always_comb begin
    fmt   = fmt_of(inst[6:0]);
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = DATA_W'($signed(imm32));
  end

endmodule

// File: rtl/ysyx_idu.sv
// ysyx_idu: instruction decode unit with a one-entry registered output stage.
//   clk, rst          : clock, synchronous active-high reset
//   prev_valid/ready_o: handshake with the fetch unit (inst, pc)
//   flush             : kill held and incoming instruction
//   valid_o/next_ready: handshake with the execute unit
//   pc_o, opcode_o, funct3_o, funct7b5_o, rd_o, rs1_o, rs2_o, imm_o,
//   wen_o, illegal_o, ebreak_o : registered decoded bundle
module ysyx_idu
  import ysyx_idu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter bit          RVE    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic [DATA_W-1:0] inst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              valid_o,
  input  logic              next_ready,
  output logic [ADDR_W-1:0] pc_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        funct3_o,
  output logic              funct7b5_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              wen_o,
  output logic              illegal_o,
  output logic              ebreak_o
);

  state_e            state_q, state_d;
  fields_t           fields_q, fields_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] imm_q, imm_d;

  logic [DATA_W-1:0] dec_imm;
  fmt_e              dec_fmt;
  fields_t           dec;
  logic              known_op, use_rd, use_rs1, use_rs2, rve_bad;
  logic              load;

  ysyx_idu_immgen #(
    .DATA_W(DATA_W)
  ) u_immgen (
    .inst(inst),
    .imm (dec_imm),
    .fmt (dec_fmt)
  );

  // Register usage per opcode drives both the RVE index check and wen.
  // CSR immediate forms (funct3[2]=1) carry a zimm in rs1, not a register.
  always_comb begin
    known_op = 1'b1;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (inst[6:0])
      OP_LUI, OP_AUIPC, OP_JAL: use_rd = 1'b1;
      OP_JALR, OP_LOAD, OP_OPIMM: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_OP: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_FENCE: known_op = 1'b1;
      OP_SYSTEM: begin
        if (inst[14:12] != 3'b000) begin
          use_rd  = 1'b1;
          use_rs1 = !inst[14];
        end
      end
      default: known_op = 1'b0;
    endcase

    rve_bad = RVE && ((use_rd && inst[11]) || (use_rs1 && inst[19]) || (use_rs2 && inst[24]));

    dec          = '0;
    dec.opcode   = inst[6:0];
    dec.funct3   = inst[14:12];
    dec.funct7b5 = inst[30];
    dec.rd       = inst[11:7];
    dec.rs1      = (dec_fmt == FMT_U || dec_fmt == FMT_J) ? 5'd0 : inst[19:15];
    dec.rs2      = use_rs2 ? inst[24:20] : 5'd0;
    dec.illegal  = !known_op || (inst[1:0] != 2'b11) || rve_bad;
    dec.wen      = use_rd && !dec.illegal && (inst[11:7] != 5'd0);
    dec.ebreak   = (inst[31:0] == INST_EBREAK);
  end

  // Fields only load on accept; on drain or flush they hold and valid_o drops.
  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (prev_valid) begin
          state_d = WAIT_READY;
          load    = 1'b1;
        end
      end
      WAIT_READY: begin
        if (next_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      load    = 1'b0;
    end

    if (load) begin
      fields_d = dec;
      pc_d     = pc;
      imm_d    = dec_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      fields_q <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
    end
  end

  assign valid_o    = (state_q == WAIT_READY);
  assign ready_o    = !valid_o;
  assign pc_o       = pc_q;
  assign imm_o      = imm_q;
  assign opcode_o   = fields_q.opcode;
  assign funct3_o   = fields_q.funct3;
  assign funct7b5_o = fields_q.funct7b5;
  assign rd_o       = fields_q.rd;
  assign rs1_o      = fields_q.rs1;
  assign rs2_o      = fields_q.rs2;
  assign wen_o      = fields_q.wen;
  assign illegal_o  = fields_q.illegal;
  assign ebreak_o   = fields_q.ebreak;

endmodule

// File: tb/tb_ysyx_idu.sv
// tb_ysyx_idu: self-checking bench for ysyx_idu (RVE=1, 32-bit).
// A behavioural model decodes each accepted instruction from the RV32I
// encoding rules and tracks the one-entry handshake per cycle.
module tb_ysyx_idu;

  logic        clk = 1'b0;
  logic        rst, prev_valid, flush, next_ready;
  logic [31:0] inst, pc;
  logic        ready_o, valid_o, funct7b5_o, wen_o, illegal_o, ebreak_o;
  logic [31:0] pc_o, imm_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        wen;
    logic        illegal;
    logic        ebreak;
  } exp_t;

  exp_t mdl;
  exp_t o;

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                           7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  ysyx_idu #(
    .ADDR_W(32),
    .DATA_W(32),
    .RVE   (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prev_valid(prev_valid),
    .ready_o   (ready_o),
    .inst      (inst),
    .pc        (pc),
    .flush     (flush),
    .valid_o   (valid_o),
    .next_ready(next_ready),
    .pc_o      (pc_o),
    .opcode_o  (opcode_o),
    .funct3_o  (funct3_o),
    .funct7b5_o(funct7b5_o),
    .rd_o      (rd_o),
    .rs1_o     (rs1_o),
    .rs2_o     (rs2_o),
    .imm_o     (imm_o),
    .wen_o     (wen_o),
    .illegal_o (illegal_o),
    .ebreak_o  (ebreak_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t obs();
    exp_t e;
    e.valid   = valid_o;
    e.ready   = ready_o;
    e.pc      = pc_o;
    e.opcode  = opcode_o;
    e.funct3  = funct3_o;
    e.f7b5    = funct7b5_o;
    e.rd      = rd_o;
    e.rs1     = rs1_o;
    e.rs2     = rs2_o;
    e.imm     = imm_o;
    e.wen     = wen_o;
    e.illegal = illegal_o;
    e.ebreak  = ebreak_o;
    return e;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p);
    exp_t        e;
    logic [31:0] sx;
    bit          known, urd, urs1, urs2;
    sx = {32{i[31]}};
    known = 1; urd = 0; urs1 = 0; urs2 = 0;
    e = '0;
    e.valid  = 1'b1;
    e.ready  = 1'b0;
    e.pc     = p;
    e.opcode = i[6:0];
    e.funct3 = i[14:12];
    e.f7b5   = i[30];
    e.rd     = i[11:7];
    case (i[6:0])
      7'h37, 7'h17: begin urd = 1; e.imm = i & 32'hFFFF_F000; end
      7'h6F: begin
        urd = 1;
        e.imm = (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      end
      7'h67, 7'h03, 7'h13: begin
        urd = 1; urs1 = 1;
        e.imm = (sx << 12) | 32'(i[31:20]);
      end
      7'h33: begin urd = 1; urs1 = 1; urs2 = 1; end
      7'h63: begin
        urs1 = 1; urs2 = 1;
        e.imm = (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      end
      7'h23: begin
        urs1 = 1; urs2 = 1;
        e.imm = (sx << 12) | (32'(i[31:25]) << 5) | 32'(i[11:7]);
      end
      7'h0F: known = 1;
      7'h73: begin
        e.imm = (sx << 12) | 32'(i[31:20]);
        if (i[14:12] != 0) begin urd = 1; urs1 = (i[14:12] < 4); end
      end
      default: known = 0;
    endcase
    e.rs1 = (i[6:0] == 7'h37 || i[6:0] == 7'h17 || i[6:0] == 7'h6F) ? 5'd0 : i[19:15];
    e.rs2 = urs2 ? i[24:20] : 5'd0;
    e.illegal = !known || (i[1:0] != 2'b11) ||
                (urd && i[11:7] >= 16) || (urs1 && i[19:15] >= 16) || (urs2 && i[24:20] >= 16);
    e.wen    = urd && !e.illegal && (i[11:7] != 0);
    e.ebreak = (i == 32'h0010_0073);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return r;
      1: return 32'h0010_0073;
      default: begin
        r[6:0] = ops[$urandom_range(0, 10)];
        return r;
      end
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input logic r, input logic pv, input logic fl, input logic nr,
                       input logic [31:0] i, input logic [31:0] p);
    rst = r; prev_valid = pv; flush = fl; next_ready = nr; inst = i; pc = p;
    if (r) mdl = '0;
    else if (fl) mdl.valid = 1'b0;
    else if (!mdl.valid && pv) mdl = ref_decode(i, p);
    else if (mdl.valid && nr) mdl.valid = 1'b0;
    mdl.ready = !mdl.valid;
    @(posedge clk);
    #1;
    o = obs();
  endtask

  task automatic test_reset();
    exp_t z;
    z = '0;
    z.ready = 1'b1;
    cycle(1, 1, 0, 0, 32'h0050_0093, 32'h8000_0000);
    cycle(1, 0, 0, 0, 32'h0, 32'h0);
    checks++;
    if (o !== z) $display("FAIL reset: got %h want %h", o, z);
    else passes++;
  endtask

  task automatic test_directed();
    logic [31:0] insts [5] = '{32'h0050_0093, 32'h1234_5137, 32'hFE00_0EE3,
                               32'h0000_0000, 32'h0010_0813};
    for (int unsigned k = 0; k < 6; k++) begin
      logic [31:0] ii;
      ii = (k == 5) ? 32'h0010_0073 : insts[k];
      cycle(0, 1, 0, 0, ii, 32'h8000_0000 + 32'(k * 4));
      checks++;
      if (o !== mdl) $display("FAIL directed_model k=%0d: got %h want %h", k, o, mdl);
      else passes++;
      checks++;
      case (k)
        0: if ({o.valid, o.rd, o.rs1, o.imm, o.wen, o.pc} !==
               {1'b1, 5'd1, 5'd0, 32'd5, 1'b1, 32'h8000_0000})
             $display("FAIL addi: got v=%b rd=%0d rs1=%0d imm=%h wen=%b pc=%h", o.valid, o.rd, o.rs1, o.imm, o.wen, o.pc);
           else passes++;
        1: if ({o.imm, o.wen} !== {32'h1234_5000, 1'b1})
             $display("FAIL lui: got imm=%h wen=%b want 12345000/1", o.imm, o.wen);
           else passes++;
        2: if ({o.imm, o.wen} !== {32'hFFFF_FFFC, 1'b0})
             $display("FAIL beq: got imm=%h wen=%b want fffffffc/0", o.imm, o.wen);
           else passes++;
        3: if ({o.illegal, o.wen, o.valid} !== 3'b101)
             $display("FAIL zero_inst: got ill=%b wen=%b v=%b want 1/0/1", o.illegal, o.wen, o.valid);
           else passes++;
        4: if ({o.illegal, o.wen} !== 2'b10)
             $display("FAIL rve_x16: got ill=%b wen=%b want 1/0", o.illegal, o.wen);
           else passes++;
        default: if ({o.ebreak, o.wen, o.illegal} !== 3'b100)
             $display("FAIL ebreak: got eb=%b wen=%b ill=%b want 1/0/0", o.ebreak, o.wen, o.illegal);
           else passes++;
      endcase
      cycle(0, 0, 0, 1, 32'h0, 32'h0);
      checks++;
      if (o !== mdl || o.valid !== 1'b0) $display("FAIL drain k=%0d: got %h want %h", k, o, mdl);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    exp_t held;
    cycle(0, 1, 0, 0, 32'h0000_8067, 32'h8000_0100);
    held = o;
    checks++;
    if (o !== mdl) $display("FAIL bp_accept: got %h want %h", o, mdl);
    else passes++;
    for (int unsigned c = 0; c < 3; c++) begin
      cycle(0, 1, 0, 0, rand_inst(), $urandom);
      checks++;
      if (o !== held || o.ready !== 1'b0) $display("FAIL bp_hold c=%0d: got %h want %h", c, o, held);
      else passes++;
    end
    cycle(0, 1, 0, 1, 32'h0050_0093, 32'h4);
    checks++;
    if (o.valid !== 1'b0 || o.ready !== 1'b1) $display("FAIL bp_release: got v=%b r=%b want 0/1", o.valid, o.ready);
    else passes++;
  endtask

  task automatic test_flush();
    cycle(0, 1, 1, 0, 32'h0050_0093, 32'h10);
    checks++;
    if (o.valid !== 1'b0 || o !== mdl) $display("FAIL flush_accept: got %h want %h", o, mdl);
    else passes++;
    cycle(0, 1, 0, 0, 32'h1234_5137, 32'h20);
    checks++;
    if (o.valid !== 1'b1 || o !== mdl) $display("FAIL flush_then_accept: got %h want %h", o, mdl);
    else passes++;
    cycle(0, 1, 1, 0, 32'h0, 32'h0);
    checks++;
    if (o.valid !== 1'b0 || o.ready !== 1'b1) $display("FAIL flush_wait: got v=%b r=%b want 0/1", o.valid, o.ready);
    else passes++;
    cycle(0, 1, 0, 0, 32'hFE00_0EE3, 32'h30);
    cycle(0, 1, 1, 1, 32'h0, 32'h0);
    checks++;
    if (o.valid !== 1'b0) $display("FAIL flush_nr: got v=%b want 0", o.valid);
    else passes++;
    cycle(0, 1, 0, 0, 32'h0010_0073, 32'h40);
    checks++;
    if (o.valid !== 1'b1 || o !== mdl) $display("FAIL flush_idle: got %h want %h", o, mdl);
    else passes++;
  endtask

  task automatic test_reset_mid();
    exp_t z;
    z = '0;
    z.ready = 1'b1;
    cycle(0, 1, 0, 0, 32'h1234_5137, 32'h8000_0000);
    cycle(1, 1, 1, 0, 32'h0050_0093, 32'h50);
    checks++;
    if (o !== z) $display("FAIL reset_mid: got %h want %h", o, z);
    else passes++;
  endtask

  task automatic test_random();
    for (int unsigned n = 0; n < 600; n++) begin
      logic r, fl;
      r  = ($urandom_range(0, 99) < 2);
      fl = ($urandom_range(0, 99) < 8);
      cycle(r, $urandom_range(0, 3) != 0, fl, $urandom_range(0, 2) == 0, rand_inst(), $urandom);
      checks++;
      if (o !== mdl) $display("FAIL random n=%0d: got %h want %h", n, o, mdl);
      else passes++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; prev_valid = 1'b0; flush = 1'b0; next_ready = 1'b0;
    inst = '0; pc = '0;
    mdl = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
